if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction fetch stage of the pipelined RV32I core; producer of the instruction word and IF/ID payload consumed by decode.
- Holds the PC and issues one word read at a time to instruction memory.
- Buffers returned words in a small fetch queue, presents them to decode under a valid/stall handshake.
- Static predict-not-taken; flushes and restarts on redirect from execute.

Parameters:
RESET_PC, 32'h1eceb000, PC of first fetch after reset
DEPTH, 4, fetch queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
imem_addr  out  32  fetch address, word-aligned
imem_rmask  out  4  4'b1111 for exactly one cycle per request, else 0
imem_rdata  in  32  returned instruction word
imem_resp  in  1  one-cycle pulse, rdata valid
redirect_valid  in  1  flush and restart fetch (taken branch/jump mispredict)
redirect_pc  in  32  restart PC, bits[1:0] ignored (forced 0)
stall  in  1  decode cannot accept this cycle
out_valid  out  1  head entry presented to decode
out_inst  out  32  head instruction word
out_pc  out  32  head PC
out_branch_pred  out  1  prediction, constant 0
out_predicted_pc  out  32  out_pc + 4

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, queue empty (head=tail=count=0), imem_rmask=0, imem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0.
- States: IDLE, WAIT, WAIT_DROP.
- IDLE: if no redirect and count+0 < DEPTH, drive imem_addr=pc, imem_rmask=4'hF this cycle -> WAIT. Else stay.
- WAIT: on imem_resp push {pc, imem_rdata}; pc<=pc+4 (32-bit wrap); ->IDLE. A new request therefore issues no earlier than the cycle after resp (1 request in flight max).
- WAIT_DROP: on imem_resp discard rdata, no push, pc unchanged -> IDLE.
- Issue condition guarantees a slot for the in-flight word: never issue when count==DEPTH.
- Pop: out_valid & ~stall at a clock edge removes head. out_* are combinational from head entry; held stable while stall=1.
- Simultaneous push and pop: count unchanged; full queue may pop and push same cycle only if a request was issued when count<DEPTH (always true by issue rule).
- Empty queue: out_valid=0, out_inst/out_pc = last head contents (don't-care for decode, but no X).
- Redirect (highest priority, any state): queue cleared (count=0, head=tail), no pop and no push that cycle, pc<=redirect_pc&~3; IDLE->IDLE, WAIT->WAIT_DROP (or ->IDLE if imem_resp same cycle, word dropped), WAIT_DROP stays WAIT_DROP (or ->IDLE on resp). No imem request is issued in the redirect cycle.
- Redirect with stall=1: flush still takes effect.
- Pointers: log2(DEPTH) bits, natural wrap; count log2(DEPTH)+1 bits.
- imem_rmask must not be asserted while state!=IDLE.

Test Plan:
- Reset release, stall=0, 1-cycle memory returning addr-derived words -> requests at 1eceb000, 1eceb004, ...; decode sees out_valid with out_pc in order, out_predicted_pc=out_pc+4, one word per 2 cycles.
- stall=1 held 10 cycles -> exactly DEPTH=4 words buffered, no further imem_rmask; head pc=1eceb000 stable; release stall -> 4 pops on consecutive cycles, fetching resumes.
- Redirect to 0x1ecec010 while WAIT (resp 3 cycles later) -> old response dropped, out_valid=0 until first word from 0x1ecec010 arrives; no stale pc ever presented.
- redirect_valid and imem_resp same cycle, queue holding 2 entries -> queue empty next cycle, responding word not enqueued, next request addr = redirect_pc.
- redirect_pc=0x1ecec013 -> fetch addr 0x1ecec010; pc 0xFFFFFFFC fetch -> next request 0x00000000.
- Assert rst=0 mid-WAIT, asynchronously -> out_valid=0 and imem_rmask=0 immediately; after release first request addr=RESET_PC, late resp from before reset is ignored.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : RV32I fetch stage -- PC, single-outstanding imem read, fetch queue
// Revision : 1.0
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_branch_pred,
  output logic [31:0] out_predicted_pc
);

  localparam int                c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT      = 2'd1,
    S_WAIT_DROP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [c_PTR_W-1:0]   head_q, tail_q;
  logic [c_PTR_W:0]     count_q;
  logic [31:0]          inst_q [DEPTH];
  logic [31:0]          ipc_q  [DEPTH];

  logic w_issue;
  logic w_push;
  logic w_pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w_issue = 1'b0;
    w_push  = 1'b0;
    w_pop   = (count_q != '0) && !stall && !redirect_valid;
    case (state_q)
      // rst gates the request so rmask stays low while reset is held
      S_IDLE: begin
        if (rst && !redirect_valid && (count_q < c_DEPTH)) begin
          w_issue = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp) begin
          w_push  = !redirect_valid;
          state_d = S_IDLE;
        end else if (redirect_valid) begin
          state_d = S_WAIT_DROP;
        end
      end
      S_WAIT_DROP: begin
        if (imem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid)  pc_d = redirect_pc & ~32'h3;
    else if (w_push)     pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect_valid) begin
        head_q  <= tail_q;
        count_q <= '0;
      end else begin
        if (w_push) begin
          inst_q[tail_q] <= imem_rdata;
          ipc_q[tail_q]  <= pc_q;
          tail_q         <= tail_q + 1'b1;
        end
        if (w_pop) head_q <= head_q + 1'b1;
        if (w_push && !w_pop)      count_q <= count_q + 1'b1;
        else if (!w_push && w_pop) count_q <= count_q - 1'b1;
      end
    end
  end

  assign imem_addr        = pc_q;
  assign imem_rmask       = w_issue ? 4'hF : 4'h0;
  assign out_valid        = (count_q != '0);
  assign out_inst         = inst_q[head_q];
  assign out_pc           = ipc_q[head_q];
  assign out_branch_pred  = 1'b0;
  assign out_predicted_pc = out_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// tb_if_stage : randomized bench for if_stage against a stream-level model
// Revision    : 1.0
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_branch_pred;
  logic [31:0] out_predicted_pc;

  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rmask      (imem_rmask),
    .imem_rdata      (imem_rdata),
    .imem_resp       (imem_resp),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .out_valid       (out_valid),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_branch_pred (out_branch_pred),
    .out_predicted_pc(out_predicted_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: decode must see a sequential PC stream from the last
  // redirect target; the queue holds accepted-but-unpopped words.
  int          mcount;
  logic [31:0] exp_pc;
  logic [31:0] req_exp;
  logic [31:0] pend_addr;
  bit          pend;
  bit          live;
  int          lat;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcount  = 0;
    exp_pc  = RESET_PC;
    req_exp = RESET_PC;
    pend    = 1'b0;
    live    = 1'b0;
    lat     = 0;
  endtask

  // stall_mode: 0 random, 1 held high, 2 held low
  task automatic step(input int stall_mode, input bit allow_rd, input int max_lat,
                      input bit rd_on_resp);
    logic        exp_issue;
    logic [31:0] tgt;
    @(negedge clk);
    imem_resp  = 1'b0;
    imem_rdata = $urandom;
    if (pend) begin
      if (lat <= 1) begin
        imem_resp  = 1'b1;
        imem_rdata = word_of(pend_addr);
        pend       = 1'b0;
      end else begin
        lat--;
      end
    end
    case (stall_mode)
      1:       stall = 1'b1;
      2:       stall = 1'b0;
      default: stall = ($urandom_range(0, 3) == 0);
    endcase
    redirect_valid = allow_rd && ($urandom_range(0, 15) == 0);
    if (rd_on_resp && imem_resp && mcount == 2) redirect_valid = 1'b1;
    case ($urandom_range(0, 3))
      0:       tgt = 32'h1ecec010;
      1:       tgt = 32'h1ecec013;
      2:       tgt = 32'hFFFFFFF4;
      default: tgt = $urandom;
    endcase
    redirect_pc = tgt;
    #1;
    exp_issue = !pend && !imem_resp && !redirect_valid && (mcount < DEPTH);
    chk("rmask", 32'(imem_rmask), exp_issue ? 32'hF : 32'h0);
    if (exp_issue) chk("req_addr", imem_addr, req_exp);
    chk("out_valid", 32'(out_valid), 32'(mcount != 0));
    if (mcount != 0) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_inst", out_inst, word_of(exp_pc));
      chk("pred_pc", out_predicted_pc, exp_pc + 32'd4);
    end
    chk("branch_pred", 32'(out_branch_pred), 32'd0);

    if (redirect_valid) begin
      mcount  = 0;
      exp_pc  = tgt & ~32'h3;
      req_exp = tgt & ~32'h3;
      live    = 1'b0;
    end else begin
      if (mcount != 0 && !stall) begin
        mcount--;
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_resp) begin
        if (live) mcount++;
        live = 1'b0;
      end
    end
    if (exp_issue) begin
      pend      = 1'b1;
      live      = 1'b1;
      pend_addr = req_exp;
      req_exp   = req_exp + 32'd4;
      lat       = $urandom_range(1, max_lat);
    end
  endtask

  initial begin
    clk            = 1'b0;
    rst            = 1'b0;
    imem_rdata     = '0;
    imem_resp      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rmask", 32'(imem_rmask), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Streaming with a 1-cycle memory
    repeat (20) step(2, 1'b0, 1, 1'b0);
    // Long stall fills the queue, then drain
    repeat (12) step(1, 1'b0, 1, 1'b0);
    repeat (8)  step(2, 1'b0, 1, 1'b0);
    // Redirect coinciding with a response while two entries are queued
    repeat (10) step(1, 1'b0, 1, 1'b1);
    repeat (10) step(2, 1'b0, 1, 1'b0);
    // Random traffic with redirects and variable latency
    repeat (400) step(0, 1'b1, 3, 1'b0);

    // Asynchronous reset while a request is in flight
    for (int k = 0; k < 20 && !pend; k++) step(2, 1'b0, 3, 1'b0);
    chk("req_inflight", 32'(pend), 32'd1);
    @(negedge clk);
    imem_resp      = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_rmask", 32'(imem_rmask), 32'd0);
    chk("arst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    imem_resp  = 1'b1;
    imem_rdata = word_of(pend_addr);
    @(negedge clk);
    imem_resp = 1'b0;
    #1;
    chk("arst_late_resp", 32'(out_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) step(0, 1'b0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
